// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access codes, FSM states and
// big-endian lane-select helpers.
package mau_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_FIN
    } mau_state_e;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    // Byte 00 sits in bits [31:24], so the right-shift distance is (3 - a) * 8.
    function automatic logic [4:0] byte_shift(input logic [1:0] a);
        return {~a, 3'b000};
    endfunction

    function automatic logic [4:0] half_shift(input logic a1);
        return {~a1, 4'b0000};
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_sub_store(input logic [3:0] op);
        case (op)
            OP_SB, OP_SH: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return (a != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge
// on big-endian word lanes.
module mau_lane
    import mau_pkg::*;
(
    input  logic [31:0] word,
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        bsh    = byte_shift(addr_lo);
        hsh    = half_shift(addr_lo[1]);
        byte_v = 8'(word >> bsh);
        half_v = 16'(word >> hsh);

        load_data = '0;
        case (op)
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {24'h0, byte_v};
            OP_LH:   load_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_data = {16'h0, half_v};
            OP_LW:   load_data = word;
            default: load_data = '0;
        endcase

        store_word = wdata;
        case (op)
            OP_SB:   store_word = (word & ~(BYTE_MASK << bsh)) | ((wdata & BYTE_MASK) << bsh);
            OP_SH:   store_word = (word & ~(HALF_MASK << hsh)) | ((wdata & HALF_MASK) << hsh);
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one request at a time, read-modify-write for
// sub-word stores. Optional misalignment trap via MAU_MISALIGN_TRAP_EN.
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
`ifdef MAU_MISALIGN_TRAP_EN
    output logic        exc,
`endif
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall
);

    mau_state_e  state;
    logic [3:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [31:0] lane_load;
    logic [31:0] lane_store;

    mau_lane u_lane (
        .word       (mem_rdata),
        .op         (op_q),
        .addr_lo    (addr_lo_q),
        .wdata      (wdata_q),
        .load_data  (lane_load),
        .store_word (lane_store)
    );

    // Request fields are pure data and need no reset.
    always_ff @(posedge clock) begin
        if (req && !busy) begin
            op_q      <= op;
            addr_lo_q <= addr[1:0];
            wdata_q   <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
            exc       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    done  <= 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
                    exc   <= 1'b0;
`endif
                    state <= ST_IDLE;
                    if (req) begin
`ifdef MAU_MISALIGN_TRAP_EN
                        if (is_misaligned(op, addr[1:0])) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            exc   <= 1'b1;
                            rdata <= '0;
                        end else
`endif
                        if (is_load(op) || is_sub_store(op)) begin
                            state    <= ST_RD;
                            busy     <= 1'b1;
                            mem_read <= 1'b1;
                            mem_addr <= {addr[31:2], 2'b00};
                        end else if (op == OP_SW) begin
                            state     <= ST_WR;
                            busy      <= 1'b1;
                            mem_write <= 1'b1;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= wdata;
                        end else begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end

                ST_RD: begin
                    if (!mem_stall) begin
                        mem_read <= 1'b0;
                        if (is_load(op_q)) begin
                            rdata <= lane_load;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FIN;
                        end else begin
                            // Sub-word store: merged word goes straight out as the write.
                            mem_wdata <= lane_store;
                            mem_write <= 1'b1;
                            state     <= ST_WR;
                        end
                    end
                end

                ST_WR: begin
                    if (!mem_stall) begin
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_FIN;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a byte-array memory
// model; honours MAU_MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

    localparam logic [3:0] LB  = 4'b0000;
    localparam logic [3:0] LH  = 4'b0001;
    localparam logic [3:0] LW  = 4'b0011;
    localparam logic [3:0] LBU = 4'b0100;
    localparam logic [3:0] LHU = 4'b0101;
    localparam logic [3:0] SB  = 4'b1000;
    localparam logic [3:0] SH  = 4'b1001;
    localparam logic [3:0] SW  = 4'b1011;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  op_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        busy, done, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_stall = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
    logic        exc;
`endif

    mem_access_unit dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .op        (op_i),
        .addr      (addr_i),
        .wdata     (wdata_i),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
`ifdef MAU_MISALIGN_TRAP_EN
        .exc       (exc),
`endif
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall)
    );

    always #5 clock = ~clock;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    int          stall_mode = 0;   // 0 none, 1 random, 2 always, 3 scripted count
    int          stall_left = 0;
    int          stall_cnt  = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] exp_word_addr = '0;
    logic [31:0] exp_wdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic model_misaligned(input logic [3:0] o, input logic [1:0] a);
`ifdef MAU_MISALIGN_TRAP_EN
        if (o == LH || o == LHU || o == SH) return a[0];
        if (o == LW || o == SW) return a != 2'b00;
        return 1'b0;
`else
        return (o == 4'hF) && (a == 2'b11) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [3:0] o,
                                               input logic [1:0] a);
        logic [7:0]  by [4];
        logic [7:0]  b;
        logic [15:0] h;
        for (int i = 0; i < 4; i++) by[i] = w[31-8*i -: 8];
        b = by[a];
        h = {by[{a[1], 1'b0}], by[{a[1], 1'b1}]};
        case (o)
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'h0, b};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            LW:      return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [3:0] o,
                                                input logic [1:0] a, input logic [31:0] wd);
        logic [7:0] by [4];
        for (int i = 0; i < 4; i++) by[i] = w[31-8*i -: 8];
        if (o == SB) by[a] = wd[7:0];
        if (o == SH) begin
            by[{a[1], 1'b0}] = wd[15:8];
            by[{a[1], 1'b1}] = wd[7:0];
        end
        if (o == SW) return wd;
        return {by[0], by[1], by[2], by[3]};
    endfunction

    // Memory responder: stall generation, read data, write commit.
    always @(negedge clock) begin
        case (stall_mode)
            0: mem_stall = 1'b0;
            1: mem_stall = ($urandom_range(0, 3) == 0);
            2: mem_stall = 1'b1;
            default: begin
                if ((mem_read || mem_write) && stall_left > 0) begin
                    mem_stall  = 1'b1;
                    stall_left = stall_left - 1;
                end else mem_stall = 1'b0;
            end
        endcase
        mem_rdata = mem[mem_addr[7:2]];
        if (reset && (mem_read || mem_write)) begin
            last_addr = mem_addr;
            if (mem_stall) stall_cnt++;
        end
        if (reset && mem_write && !mem_stall) begin
            chk("mem_wdata", mem_wdata, exp_wdata);
            mem[mem_addr[7:2]] = mem_wdata;
        end
    end

    // Per-cycle protocol compare.
    always @(negedge clock) begin
        if (reset) begin
            chk("strobe_excl", {31'h0, mem_read && mem_write}, 32'h0);
            chk("busy_vs_strobe", {31'h0, busy}, {31'h0, mem_read || mem_write});
            if (mem_read || mem_write) chk("mem_addr", mem_addr, exp_word_addr);
        end
    end

    task automatic run_txn(input logic [3:0] t_op, input logic [31:0] t_addr,
                           input logic [31:0] t_wd, output logic [31:0] got_rd, output int lat);
        int          idx;
        int          n_acc;
        int          busy_cnt;
        logic        mis;
        logic        ld;
        logic        st;
        logic        done_seen;
        logic [31:0] exp_rd;
        idx    = int'(t_addr[7:2]);
        mis    = model_misaligned(t_op, t_addr[1:0]);
        ld     = (t_op == LB || t_op == LH || t_op == LW || t_op == LBU || t_op == LHU);
        st     = (t_op == SB || t_op == SH || t_op == SW);
        exp_rd = 32'h0;
        n_acc  = 0;
        if (!mis && ld) begin
            n_acc  = 1;
            exp_rd = model_load(ref_mem[idx], t_op, t_addr[1:0]);
        end else if (!mis && st) begin
            n_acc        = (t_op == SW) ? 1 : 2;
            exp_wdata    = model_merge(ref_mem[idx], t_op, t_addr[1:0], t_wd);
            ref_mem[idx] = exp_wdata;
        end
        exp_word_addr = {t_addr[31:2], 2'b00};
        req = 1'b1; op_i = t_op; addr_i = t_addr; wdata_i = t_wd;
        @(posedge clock);
        #1;
        req = 1'b0; op_i = 4'($urandom); addr_i = $urandom; wdata_i = $urandom;
        stall_cnt = 0; lat = 0; busy_cnt = 0; done_seen = 1'b0;
        while (!done_seen && lat < 200) begin
            @(negedge clock);
            lat++;
            if (busy) busy_cnt++;
            if (done) done_seen = 1'b1;
        end
        chk("done_seen", {31'h0, done_seen}, 32'h1);
        chk("latency", lat, n_acc + stall_cnt + 1);
        chk("busy_cycles", busy_cnt, lat - 1);
        if (ld || n_acc == 0) chk("rdata", rdata, exp_rd);
`ifdef MAU_MISALIGN_TRAP_EN
        chk("exc", {31'h0, exc}, {31'h0, mis});
`endif
        if (st && !mis) chk("mem_word", mem[idx], ref_mem[idx]);
        got_rd = rdata;
    endtask

    task automatic set_word(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          dcnt;
        logic        seen;
        logic [3:0]  op_tab [10];
        op_tab = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 4'b0010, 4'b1111};
        for (int i = 0; i < 64; i++) set_word(i, $urandom);

        repeat (3) @(negedge clock);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
`ifdef MAU_MISALIGN_TRAP_EN
        chk("rst_exc", {31'h0, exc}, 32'h0);
`endif
        reset = 1'b1;
        @(negedge clock);

        // Directed cases with literal expectations.
        set_word(4, 32'hDEADBEEF);
        run_txn(LW, 32'h10, 32'h0, rd, lat);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_lat", lat, 2);
        chk("lw_addr", last_addr, 32'h10);

        set_word(8, 32'h80FF7F01);
        run_txn(LB, 32'h21, 32'h0, rd, lat);
        chk("lb21", rd, 32'hFFFFFFFF);
        run_txn(LBU, 32'h21, 32'h0, rd, lat);
        chk("lbu21", rd, 32'h000000FF);
        run_txn(LB, 32'h22, 32'h0, rd, lat);
        chk("lb22", rd, 32'h0000007F);

        set_word(16, 32'h11223344);
        stall_mode = 3; stall_left = 3;
        run_txn(SB, 32'h42, 32'h000000AA, rd, lat);
        chk("sb_lat", lat, 6);
        chk("sb_word", mem[16], 32'h1122AA44);
        chk("sb_addr", last_addr, 32'h40);
        stall_mode = 0;

        run_txn(SW, 32'h50, 32'h12345678, rd, lat);
        run_txn(LW, 32'h50, 32'h0, rd, lat);
        chk("b2b_lat", lat, 2);
        chk("b2b_rdata", rd, 32'h12345678);

        set_word(0, 32'h0BADF00D);
        last_addr = 32'hFFFFFFFF;
        run_txn(LW, 32'h102, 32'h0, rd, lat);
`ifdef MAU_MISALIGN_TRAP_EN
        chk("mis_lat", lat, 1);
        chk("mis_rdata", rd, 32'h0);
        chk("mis_nostrobe", last_addr, 32'hFFFFFFFF);
`else
        chk("unal_addr", last_addr, 32'h100);
        chk("unal_rdata", rd, 32'h0BADF00D);
`endif

        // Asynchronous reset while a write is stalled.
        stall_mode = 2;
        exp_word_addr = 32'h30; exp_wdata = 32'hCAFEF00D;
        req = 1'b1; op_i = SW; addr_i = 32'h30; wdata_i = 32'hCAFEF00D;
        @(posedge clock);
        #1 req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (mem_write) seen = 1'b1;
        end
        chk("arst_wr_seen", {31'h0, seen}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("arst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_mem_wdata", mem_wdata, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        repeat (2) @(negedge clock);
        stall_mode = 0;
        reset = 1'b1;
        dcnt = 0;
        repeat (5) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        chk("arst_no_done", dcnt, 0);
        chk("arst_no_write", mem[12], ref_mem[12]);
        run_txn(LHU, 32'h12, 32'h0, rd, lat);
        chk("arst_after_lat", lat, 2);

        // Randomized traffic with random stalls and idle gaps.
        stall_mode = 1;
        for (int n = 0; n < 250; n++) begin
            run_txn(op_tab[$urandom_range(0, 9)], $urandom, $urandom, rd, lat);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        stall_mode = 0;
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
